// File: rtl/jtopl_pkg.sv
// Shared constants, types and the rhythm ring-modulation term for the OPL
// phase path, so the sequencer and any reference model agree on them.
package jtopl_pkg;

    localparam int SLOTS   = 18;
    localparam int HH_SLOT = 14;
    localparam int SD_SLOT = 15;
    localparam int TC_SLOT = 17;
    localparam int LFSR_W  = 23;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h1;

    typedef struct packed {
        logic hh;
        logic sd;
        logic tc;
    } rhy_en_t;

    function automatic logic rm_xor_f(input logic [9:0] hh, input logic [9:0] tc);
        return (hh[2] ^ hh[7]) | (hh[3] ^ tc[5]) | (tc[3] ^ tc[5]);
    endfunction

endpackage

// File: rtl/jtopl_noise_lfsr.sv
// Fibonacci noise LFSR with a step enable; recovers from the lock-up state
// by reloading the seed.
module jtopl_noise_lfsr
    import jtopl_pkg::*;
#(
    parameter int              W    = LFSR_W,
    parameter int              TAP  = 8,
    parameter logic [W-1:0]    SEED = LFSR_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cen,
    input  logic i_step,
    output logic o_noise
);

    logic [W-1:0] r_lfsr;
    logic [W-1:0] w_next;
    logic         w_fb;

    always_comb begin
        w_fb   = r_lfsr[W-1] ^ r_lfsr[TAP];
        w_next = (r_lfsr == '0) ? SEED : {r_lfsr[W-2:0], w_fb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= SEED;
        else if (i_cen && i_step)
            r_lfsr <= w_next;
    end

    assign o_noise = r_lfsr[W-1];

endmodule

// File: rtl/jtopl_rhy_ctrl.sv
// Rhythm-mode sequencer: slot counter, HH/SD/TC enables, HH/TC phase capture,
// ring-modulation term and the per-frame noise source.
module jtopl_rhy_ctrl #(
    parameter int                                SLOTS     = jtopl_pkg::SLOTS,
    parameter int                                HH_SLOT   = jtopl_pkg::HH_SLOT,
    parameter int                                SD_SLOT   = jtopl_pkg::SD_SLOT,
    parameter int                                TC_SLOT   = jtopl_pkg::TC_SLOT,
    parameter logic [jtopl_pkg::LFSR_W-1:0]      LFSR_SEED = jtopl_pkg::LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       zero,
    input  logic       rhy_en,
    input  logic [9:0] phase_pre,
    output logic [4:0] slot,
    output logic [9:0] hh,
    output logic       hh_en,
    output logic       sd_en,
    output logic       tc_en,
    output logic       rm_xor,
    output logic       noise
);

    import jtopl_pkg::*;

    localparam logic [4:0] LAST   = 5'(SLOTS - 1);
    localparam logic [4:0] HH_IDX = 5'(HH_SLOT);
    localparam logic [4:0] SD_IDX = 5'(SD_SLOT);
    localparam logic [4:0] TC_IDX = 5'(TC_SLOT);

    logic [4:0] r_slot;
    logic [9:0] r_hh;
    logic [9:0] r_tc;
    logic       w_last;
    rhy_en_t    w_en;

    assign w_last = (r_slot == LAST);

    // Captures ignore rhy_en so the phases are already valid when rhythm mode turns on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_hh   <= '0;
            r_tc   <= '0;
        end else if (cen) begin
            r_slot <= (zero || w_last) ? 5'd0 : r_slot + 5'd1;
            if (r_slot == HH_IDX)
                r_hh <= phase_pre;
            if (r_slot == TC_IDX)
                r_tc <= phase_pre;
        end
    end

    always_comb begin
        w_en    = '0;
        w_en.hh = rhy_en && (r_slot == HH_IDX);
        w_en.sd = rhy_en && (r_slot == SD_IDX);
        w_en.tc = rhy_en && (r_slot == TC_IDX);
    end

    // One noise step per sample frame, taken on the last slot even if zero resyncs it.
    jtopl_noise_lfsr #(
        .W    (LFSR_W),
        .TAP  (8),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_cen   (cen),
        .i_step  (w_last),
        .o_noise (noise)
    );

    assign slot   = r_slot;
    assign hh     = r_hh;
    assign hh_en  = w_en.hh;
    assign sd_en  = w_en.sd;
    assign tc_en  = w_en.tc;
    assign rm_xor = rm_xor_f(r_hh, r_tc);

endmodule

// File: tb/tb_jtopl_rhy_ctrl.sv
// Scoreboard bench for jtopl_rhy_ctrl: stimulus pushes expected state, a
// negedge monitor pops and compares.
module tb_jtopl_rhy_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       zero;
    logic       rhy_en;
    logic [9:0] phase_pre;
    logic [4:0] slot;
    logic [9:0] hh;
    logic       hh_en;
    logic       sd_en;
    logic       tc_en;
    logic       rm_xor;
    logic       noise;

    jtopl_rhy_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .zero      (zero),
        .rhy_en    (rhy_en),
        .phase_pre (phase_pre),
        .slot      (slot),
        .hh        (hh),
        .hh_en     (hh_en),
        .sd_en     (sd_en),
        .tc_en     (tc_en),
        .rm_xor    (rm_xor),
        .noise     (noise)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  slot;
        logic [9:0]  hh;
        logic [9:0]  tc;
        logic [2:0]  en;
        logic        rm;
        logic        noise;
        logic [22:0] lfsr;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_tchk = 0;
    int   n_tpass = 0;

    // reference model state
    logic [4:0]  m_slot;
    logic [9:0]  m_hh;
    logic [9:0]  m_tc;
    logic [22:0] m_lfsr;

    task automatic chk(input string n, input string f, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s.%s got=%0h exp=%0h @%0t", n, f, got, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "slot",  32'(slot),  32'(e.slot));
            chk(e.name, "hh",    32'(hh),    32'(e.hh));
            chk(e.name, "tc_q",  32'(dut.r_tc), 32'(e.tc));
            chk(e.name, "en",    32'({hh_en, sd_en, tc_en}), 32'(e.en));
            chk(e.name, "rm_xor", 32'(rm_xor), 32'(e.rm));
            chk(e.name, "noise", 32'(noise), 32'(e.noise));
            chk(e.name, "lfsr",  32'(dut.u_lfsr.r_lfsr), 32'(e.lfsr));
        end
    end

    function automatic exp_t mk(input string nm);
        exp_t e;
        e.name  = nm;
        e.slot  = m_slot;
        e.hh    = m_hh;
        e.tc    = m_tc;
        e.en    = {rhy_en && m_slot == 5'd14, rhy_en && m_slot == 5'd15, rhy_en && m_slot == 5'd17};
        e.rm    = (m_hh[2] ^ m_hh[7]) | (m_hh[3] ^ m_tc[5]) | (m_tc[3] ^ m_tc[5]);
        e.noise = m_lfsr[22];
        e.lfsr  = m_lfsr;
        return e;
    endfunction

    function automatic exp_t hand(input string nm, input logic [4:0] s, input logic [9:0] h,
                                  input logic [9:0] t, input logic [2:0] en, input logic rm,
                                  input logic n, input logic [22:0] l);
        exp_t e;
        e.name = nm; e.slot = s; e.hh = h; e.tc = t; e.en = en; e.rm = rm; e.noise = n; e.lfsr = l;
        return e;
    endfunction

    task automatic model_reset();
        m_slot = '0; m_hh = '0; m_tc = '0; m_lfsr = 23'h1;
    endtask

    task automatic model_step(input logic c, input logic z, input logic [9:0] p);
        if (c) begin
            if (m_slot == 5'd14) m_hh = p;
            if (m_slot == 5'd17) begin
                m_tc   = p;
                m_lfsr = (m_lfsr == '0) ? 23'h1 : {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[8]};
            end
            m_slot = (z || m_slot == 5'd17) ? 5'd0 : m_slot + 5'd1;
        end
    endtask

    // ovr >= 0 forces a hand-derived noise expectation
    task automatic tick(input logic c, input logic z, input logic r, input logic [9:0] p,
                        input string nm, input int ovr = -1);
        exp_t e;
        cen = c; zero = z; rhy_en = r; phase_pre = p;
        @(posedge clk); #1;
        model_step(c, z, p);
        e = mk(nm);
        if (ovr >= 0) e.noise = ovr[0];
        q.push_back(e);
        @(negedge clk); #1;
    endtask

    task automatic tick_h(input logic c, input logic z, input logic r, input logic [9:0] p, input exp_t h);
        cen = c; zero = z; rhy_en = r; phase_pre = p;
        @(posedge clk); #1;
        model_step(c, z, p);
        q.push_back(h);
        @(negedge clk); #1;
    endtask

    task automatic goto_slot(input logic [4:0] target, input logic r, input string nm);
        for (int i = 0; i < 40 && m_slot != target; i++)
            tick(1'b1, 1'b0, r, 10'(m_slot * 29 + 3), nm);
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; zero = 1'b0; rhy_en = 1'b1; phase_pre = 10'h3ff;
        model_reset();
        #2;
        q.push_back(hand("reset", 5'd0, 10'h0, 10'h0, 3'b000, 1'b0, 1'b0, 23'h1));
        @(negedge clk); #1;
        rst_n = 1'b1;

        // frame 1: rhythm on, HH=084 TC=028
        tick(1'b1, 1'b1, 1'b1, 10'h155, "sync0");
        for (int s = 0; s < 18; s++) begin
            if (s == 14)
                tick_h(1'b1, 1'b0, 1'b1, 10'h084,
                       hand("f1_hh", 5'd15, 10'h084, 10'h000, 3'b010, 1'b0, 1'b0, 23'h1));
            else if (s == 17)
                tick_h(1'b1, 1'b0, 1'b1, 10'h028,
                       hand("f1_tc", 5'd0, 10'h084, 10'h028, 3'b000, 1'b1, 1'b0, 23'h2));
            else
                tick(1'b1, 1'b0, 1'b1, 10'h155, "f1");
        end

        // frame 2: rhythm off, zero phases
        for (int s = 0; s < 18; s++) begin
            if (s == 14)
                tick_h(1'b1, 1'b0, 1'b0, 10'h000,
                       hand("f2_hh", 5'd15, 10'h000, 10'h028, 3'b000, 1'b1, 1'b0, 23'h2));
            else if (s == 17)
                tick_h(1'b1, 1'b0, 1'b0, 10'h000,
                       hand("f2_tc", 5'd0, 10'h000, 10'h000, 3'b000, 1'b0, 1'b0, 23'h4));
            else
                tick(1'b1, 1'b0, 1'b0, 10'h2aa, "f2");
        end

        // frames 3..64: LFSR run, rhythm toggled per frame and mid-frame
        for (int k = 3; k <= 64; k++) begin
            for (int s = 0; s < 18; s++) begin
                logic r;
                r = (k[0] ^ (s >= 15));
                if (s == 17 && (k == 21 || k == 22))
                    tick(1'b1, 1'b0, r, 10'(s * 37 + k * 11), "lfsr_b22", (k == 22) ? 1 : 0);
                else
                    tick(1'b1, 1'b0, r, 10'(s * 37 + k * 11), "lfsr");
            end
        end

        // cen low at slot 14 holds everything, even with zero high
        goto_slot(5'd14, 1'b1, "to14");
        for (int i = 0; i < 10; i++)
            tick(1'b0, 1'b1, 1'b1, 10'h2aa, "cen_hold");
        tick(1'b1, 1'b0, 1'b1, 10'h2aa, "cen_cap");
        tick(1'b1, 1'b0, 1'b1, 10'h111, "cen_once");

        // zero resync mid-frame and on the last slot
        goto_slot(5'd9, 1'b1, "to9");
        tick(1'b1, 1'b1, 1'b1, 10'h0f0, "zero_s9");
        goto_slot(5'd17, 1'b0, "to17");
        tick(1'b1, 1'b1, 1'b0, 10'h0f0, "zero_s17");

        // async reset at slot 16
        for (int f = 0; f < 3; f++) begin
            goto_slot(5'd17, 1'b1, "frames");
            tick(1'b1, 1'b0, 1'b1, 10'h3c3, "frames");
        end
        goto_slot(5'd16, 1'b1, "to16");
        rhy_en = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        q.push_back(hand("rst_mid", 5'd0, 10'h0, 10'h0, 3'b000, 1'b0, 1'b0, 23'h1));
        @(negedge clk); #1;
        cen = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            tick(1'b1, 1'b0, 1'b1, 10'h077, "post_rst");

        // drain: bounded wait for the monitor
        begin
            int w;
            w = 0;
            while (q.size() > 0 && w < 100) begin
                @(negedge clk); #1;
                w++;
            end
            n_tchk++;
            if (q.size() != 0)
                $display("FAIL drain got=%0d pending exp=0", q.size());
            else
                n_tpass++;
        end

        $display("%0d/%0d checks passed", n_pass + n_tpass, n_chk + n_tchk);
        $finish;
    end

endmodule
